// File: rtl/status_array_sweeper.sv
// Write-port sequencer for the icache status array: power-on sweep of every row,
// then resident range-flush engine with wrapping ranges and a per-request block mask.
module status_array_sweeper #(
    parameter int unsigned          ADDR_WIDTH = 6,
    parameter int unsigned          ROW_WIDTH  = 8,
    parameter int unsigned          NUM_BLOCKS = 4,
    parameter logic [ROW_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_base,
    input  logic [ADDR_WIDTH-1:0] i_req_last,
    input  logic [NUM_BLOCKS-1:0] i_req_wmask,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ROW_WIDTH-1:0]  o_data,
    output logic                  o_wen,
    output logic [NUM_BLOCKS-1:0] o_wmask,
    output logic                  o_valid,
    output logic                  o_init_complete,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ROW_WIDTH-1:0]  data_q, data_d;
    logic [NUM_BLOCKS-1:0] wmask_q, wmask_d;
    logic                  wen_q, wen_d;
    logic                  init_q, init_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // State and output registers; everything holds while halted via the next-state defaults
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wmask_q <= '0;
            wen_q   <= 1'b0;
            init_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wmask_q <= wmask_d;
            wen_q   <= wen_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and registered-output logic; the counter's extra top bit marks sweep end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wmask_d = wmask_q;
        wen_d   = wen_q;
        init_d  = init_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (!i_halt) begin
            done_d = 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (cnt_q[ADDR_WIDTH]) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                        addr_d  = '0;
                        data_d  = '0;
                        wmask_d = '0;
                        wen_d   = 1'b0;
                        init_d  = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = cnt_q[ADDR_WIDTH-1:0];
                        data_d  = INIT_VALUE;
                        wmask_d = '1;
                        wen_d   = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    addr_d  = '0;
                    data_d  = '0;
                    wmask_d = '0;
                    wen_d   = 1'b0;
                    if (i_req_valid) begin
                        state_d = ST_FLUSH;
                        last_d  = i_req_last;
                        addr_d  = i_req_base;
                        data_d  = INIT_VALUE;
                        wmask_d = i_req_wmask;
                        wen_d   = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (addr_q != last_q) begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end else begin
                        state_d = ST_READY;
                        addr_d  = '0;
                        data_d  = '0;
                        wmask_d = '0;
                        wen_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    addr_d  = '0;
                    data_d  = '0;
                    wmask_d = '0;
                    wen_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            endcase
        end
    end

    assign o_addr          = addr_q;
    assign o_data          = data_q;
    assign o_wen           = wen_q;
    assign o_valid         = wen_q;
    assign o_wmask         = wmask_q;
    assign o_init_complete = init_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_ready         = (state_q == ST_READY) & ~i_halt;

endmodule

// File: tb/tb_status_array_sweeper.sv
// Bench for status_array_sweeper: directed scenarios plus random traffic, checked every
// cycle against a queue-of-pending-rows transaction model.
module tb_status_array_sweeper;

    localparam int unsigned AW = 3;
    localparam int unsigned RW = 8;
    localparam int unsigned NB = 4;
    localparam int unsigned D  = 1 << AW;
    localparam logic [RW-1:0] IV = 8'hA5;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          i_halt = 1'b0;
    logic          i_req_valid = 1'b0;
    logic [AW-1:0] i_req_base = '0;
    logic [AW-1:0] i_req_last = '0;
    logic [NB-1:0] i_req_wmask = '0;
    logic [AW-1:0] o_addr;
    logic [RW-1:0] o_data;
    logic          o_wen;
    logic [NB-1:0] o_wmask;
    logic          o_valid;
    logic          o_init_complete;
    logic          o_ready;
    logic          o_busy;
    logic          o_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    status_array_sweeper #(
        .ADDR_WIDTH(AW),
        .ROW_WIDTH (RW),
        .NUM_BLOCKS(NB),
        .INIT_VALUE(IV)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .i_halt         (i_halt),
        .i_req_valid    (i_req_valid),
        .i_req_base     (i_req_base),
        .i_req_last     (i_req_last),
        .i_req_wmask    (i_req_wmask),
        .o_addr         (o_addr),
        .o_data         (o_data),
        .o_wen          (o_wen),
        .o_wmask        (o_wmask),
        .o_valid        (o_valid),
        .o_init_complete(o_init_complete),
        .o_ready        (o_ready),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    // Reference model: rows still to be written for the current operation, in order
    int            pend[$];
    logic [NB-1:0] op_mask = '1;
    logic          m_wen = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [RW-1:0] m_data = '0;
    logic [NB-1:0] m_mask = '0;
    logic          m_busy = 1'b1;
    logic          m_init = 1'b0;
    logic          m_done = 1'b0;
    logic          m_acc = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_wen  = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_mask = '0;
    endtask

    task automatic model_pop();
        m_wen  = 1'b1;
        m_addr = AW'(pend.pop_front());
        m_data = IV;
        m_mask = op_mask;
    endtask

    task automatic model_edge();
        int n;
        m_acc = 1'b0;
        if (!arst_n) begin
            pend.delete();
            for (int i = 0; i < int'(D); i++) pend.push_back(i);
            op_mask = '1;
            model_clear();
            m_busy = 1'b1;
            m_init = 1'b0;
            m_done = 1'b0;
        end else if (!i_halt) begin
            m_done = 1'b0;
            if (pend.size() > 0) begin
                model_pop();
            end else if (m_busy) begin
                model_clear();
                m_busy = 1'b0;
                m_done = 1'b1;
                m_init = 1'b1;
            end else begin
                model_clear();
                if (i_req_valid) begin
                    n = ((int'(i_req_last) - int'(i_req_base) + int'(D)) % int'(D)) + 1;
                    for (int i = 0; i < n; i++) pend.push_back((int'(i_req_base) + i) % int'(D));
                    op_mask = i_req_wmask;
                    m_busy  = 1'b1;
                    m_acc   = 1'b1;
                    model_pop();
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("wen",   32'(o_wen),           32'(m_wen));
        check_eq("valid", 32'(o_valid),         32'(m_wen));
        check_eq("addr",  32'(o_addr),          32'(m_addr));
        check_eq("data",  32'(o_data),          32'(m_data));
        check_eq("wmask", 32'(o_wmask),         32'(m_mask));
        check_eq("init",  32'(o_init_complete), 32'(m_init));
        check_eq("busy",  32'(o_busy),          32'(m_busy));
        check_eq("done",  32'(o_done),          32'(m_done));
        check_eq("ready", 32'(o_ready),         32'(!m_busy && !i_halt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_accept(input int bound);
        int k = 0;
        while (!m_acc && k < bound) begin
            step();
            k++;
        end
        if (!m_acc) check_eq("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (m_busy && k < bound) begin
            step();
            k++;
        end
        if (m_busy) check_eq("idle_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_flush(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [NB-1:0] m);
        i_req_valid = 1'b1;
        i_req_base  = b;
        i_req_last  = l;
        i_req_wmask = m;
        wait_accept(40);
        i_req_valid = 1'b0;
        wait_idle(40);
        step();
    endtask

    initial begin
        // Reset with a request already held through the sweep
        arst_n      = 1'b0;
        i_req_valid = 1'b1;
        i_req_base  = 3'd2;
        i_req_last  = 3'd5;
        i_req_wmask = 4'b0101;
        step();
        step();
        #1 arst_n = 1'b1;
        wait_accept(40);
        i_req_valid = 1'b0;
        wait_idle(40);
        step();

        do_flush(3'd6, 3'd1, 4'b1100);
        do_flush(3'd3, 3'd3, 4'b0010);
        do_flush(3'd4, 3'd3, 4'b1001);

        // Halt three cycles on the second write of a 2..5 flush
        i_req_valid = 1'b1;
        i_req_base  = 3'd2;
        i_req_last  = 3'd5;
        i_req_wmask = 4'b0110;
        wait_accept(40);
        i_req_valid = 1'b0;
        step();
        i_halt = 1'b1;
        repeat (3) step();
        i_halt = 1'b0;
        wait_idle(40);
        step();

        // Halt while idle blocks acceptance
        i_halt      = 1'b1;
        i_req_valid = 1'b1;
        i_req_base  = 3'd0;
        i_req_last  = 3'd7;
        repeat (2) step();
        i_halt = 1'b0;
        wait_accept(10);
        i_req_valid = 1'b0;
        step();
        step();
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        wait_idle(40);
        step();

        // Back-to-back requests with the mask changing every cycle
        i_req_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            i_req_base  = AW'($urandom);
            i_req_last  = AW'($urandom);
            i_req_wmask = NB'($urandom);
            step();
        end

        // Random traffic with halts and occasional resets
        for (int c = 0; c < 1500; c++) begin
            arst_n      = ($urandom_range(0, 299) != 0);
            i_halt      = ($urandom_range(0, 5) == 0);
            i_req_valid = ($urandom_range(0, 1) == 1);
            i_req_base  = AW'($urandom);
            i_req_last  = AW'($urandom);
            i_req_wmask = NB'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
